// File: rtl/cpu_pkg.sv
// Shared core definitions: register-file size, PC index, write-back entry type
// and the 4-to-16 one-hot decoder used for register write enables.
package cpu_pkg;

  localparam int NREG = 16;
  localparam logic [3:0] REG_PC = 4'd15;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  function automatic logic [15:0] onehot16(input logic [3:0] rd);
    logic [15:0] v;
    v = '0;
    v[rd] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Load-result buffer for the write-back arbiter: a DEPTH-entry circular FIFO
// with per-slot occupancy, plus a registered mask of destination registers
// held in occupied slots.
import cpu_pkg::*;

module wb_fifo #(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_push,
  input  logic            i_pop,
  input  wb_entry_t       i_din,
  output wb_entry_t       o_head,
  output logic            o_full,
  output logic            o_empty,
  output logic [NREG-1:0] o_pend
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t        r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [NREG-1:0]  r_pend;

  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_vld_nxt;
  logic [NREG-1:0]  w_pend_nxt;
  logic [3:0]       w_rd_nxt;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_pend  = r_pend;

  // A full FIFO never takes a push, even when it pops the same cycle.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Next occupancy and the destination mask it implies, so ld_pend tracks the FIFO state edge-for-edge.
  always_comb begin
    w_vld_nxt  = r_vld;
    w_pend_nxt = '0;
    w_rd_nxt   = '0;
    if (w_pop)  w_vld_nxt[r_rd_ptr] = 1'b0;
    if (w_push) w_vld_nxt[r_wr_ptr] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      w_rd_nxt = (w_push && (AW'(i) == r_wr_ptr)) ? i_din.rd : r_mem[i].rd;
      if (w_vld_nxt[i]) w_pend_nxt = w_pend_nxt | NREG'(onehot16(w_rd_nxt));
    end
  end

  // Storage, pointers (wrap naturally since DEPTH is a power of two) and count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_pend   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_vld   <= w_vld_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results (never stalled) and load results
// (buffered in wb_fifo on collision) into one registered register-file write.
// Optional build macro WB_STALL_CNT_EN adds a saturating load-stall counter.
import cpu_pkg::*;

module wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int NREG  = cpu_pkg::NREG
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_alu_valid,
  input  logic [3:0]      i_alu_rd,
  input  logic [31:0]     i_alu_data,
  input  logic            i_ld_valid,
  output logic            o_ld_ready,
  input  logic [3:0]      i_ld_rd,
  input  logic [31:0]     i_ld_data,
  output logic [NREG-1:0] o_wr_sel,
  output logic [31:0]     o_wr_data,
  output logic            o_pc_write,
  output logic [NREG-1:0] o_ld_pend
`ifdef WB_STALL_CNT_EN
  ,
  output logic [31:0]     o_stall_cnt
`endif
);

  logic [NREG-1:0] r_wr_sel;
  logic [31:0]     r_wr_data;
  logic            r_pc_write;

  wb_entry_t       w_head;
  wb_entry_t       w_ld_entry;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_direct;
  logic            w_issue;
  logic [3:0]      w_rd;
  logic [31:0]     w_data;
  logic [NREG-1:0] w_fifo_pend;

  assign w_ld_entry = '{rd: i_ld_rd, data: i_ld_data};
  assign o_ld_ready = !w_full;

  // Priority: ALU, then FIFO head, then a load straight through when nothing is queued.
  always_comb begin
    w_pop    = !i_alu_valid && !w_empty;
    w_direct = !i_alu_valid && w_empty && i_ld_valid;
    w_push   = i_ld_valid && o_ld_ready && !w_direct;
    w_issue  = i_alu_valid || !w_empty || i_ld_valid;
    w_rd     = i_ld_rd;
    w_data   = i_ld_data;
    if (i_alu_valid) begin
      w_rd   = i_alu_rd;
      w_data = i_alu_data;
    end else if (!w_empty) begin
      w_rd   = w_head.rd;
      w_data = w_head.data;
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_ld_entry),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_pend  (w_fifo_pend)
  );

  // Registered write strobe; data holds when nothing is written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_sel   <= '0;
      r_wr_data  <= '0;
      r_pc_write <= 1'b0;
    end else begin
      r_wr_sel   <= w_issue ? NREG'(onehot16(w_rd)) : '0;
      r_pc_write <= w_issue && (w_rd == REG_PC);
      if (w_issue) r_wr_data <= w_data;
    end
  end

  assign o_wr_sel   = r_wr_sel;
  assign o_wr_data  = r_wr_data;
  assign o_pc_write = r_pc_write;
  assign o_ld_pend  = w_fifo_pend;

`ifdef WB_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Count cycles a load is offered but refused; sticks at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                                r_stall_cnt <= '0;
    else if (i_ld_valid && !o_ld_ready && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
